// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg
//   Shared definitions for the decode stage: ALU operation encodings seen by
//   execute, the RV32I opcodes this stage understands, the immediate formats
//   and a helper that builds a sign-extended immediate from an instruction word.
package decode_stage_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_U = 2'b11
   } imm_type_e;

   // Reassemble the scattered immediate fields of each format into a 32-bit value.
   function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_type_e kind);
      logic [31:0] imm;
      case (kind)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'd0};
         default: imm = 32'd0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// decode_stage_regfile
//   32-entry architectural register file with x0 hardwired to zero.
//   Ports: clk_i/rst_i (sync active-high reset clears every entry),
//   we_i/waddr_i/wdata_i (posedge write, x0 ignored),
//   raddr1_i/raddr2_i -> rdata1_o/rdata2_o (asynchronous reads).
//   A read of the register being written in the same cycle returns the new
//   value, so a decode that coincides with writeback sees fresh data.
module decode_stage_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic [4:0]            waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [4:0]            raddr1_i,
   input  logic [4:0]            raddr2_i,
   output logic [DATA_WIDTH-1:0] rdata1_o,
   output logic [DATA_WIDTH-1:0] rdata2_o
);

   logic [DATA_WIDTH-1:0] mem_q [REG_COUNT];
   logic                  wr_en_s;

   assign wr_en_s = we_i && (waddr_i != 5'd0);

   // Register storage: cleared on reset, one write per cycle from writeback.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            mem_q[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (wr_en_s) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // x0 reads as zero; a same-cycle write to the addressed register bypasses storage.
   assign rdata1_o = (raddr1_i == 5'd0)                  ? {DATA_WIDTH{1'b0}} :
                     (wr_en_s && (waddr_i == raddr1_i)) ? wdata_i : mem_q[raddr1_i];
   assign rdata2_o = (raddr2_i == 5'd0)                  ? {DATA_WIDTH{1'b0}} :
                     (wr_en_s && (waddr_i == raddr2_i)) ? wdata_i : mem_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// decode_stage
//   Decodes one RV32I instruction per valid/ready handshake and presents
//   registered operands and control to execute one cycle later.
//   Ports: clk_i, rst_i (sync active-high); in_valid_i/in_ready_o/instr_i from
//   fetch; wb_en_i/wb_rd_i/wb_data_i from writeback; flush_i kills the held and
//   incoming instruction; out_valid_o/out_ready_i handshake to execute with
//   reg_data1_o, reg_data2_o, imm_ext_o, ALUctrl_o, ALUsrc_o, rd_o, reg_write_o,
//   mem_read_o, mem_write_o, branch_o, illegal_o.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_COUNT  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [31:0]           instr_i,
   input  logic                  wb_en_i,
   input  logic [4:0]            wb_rd_i,
   input  logic [DATA_WIDTH-1:0] wb_data_i,
   input  logic                  flush_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] reg_data1_o,
   output logic [DATA_WIDTH-1:0] reg_data2_o,
   output logic [DATA_WIDTH-1:0] imm_ext_o,
   output logic [3:0]            ALUctrl_o,
   output logic                  ALUsrc_o,
   output logic [4:0]            rd_o,
   output logic                  reg_write_o,
   output logic                  mem_read_o,
   output logic                  mem_write_o,
   output logic                  branch_o,
   output logic                  illegal_o
);

   logic [6:0]            opcode_s, funct7_s;
   logic [2:0]            funct3_s;
   logic [DATA_WIDTH-1:0] rdata1_s, rdata2_s;
   logic [3:0]            alu_raw_s;
   logic [DATA_WIDTH-1:0] imm_raw_s;
   logic                  src_raw_s, rw_raw_s, mr_raw_s, mw_raw_s, br_raw_s, lui_s, ill_s;
   logic                  load_s;

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data1_q, data1_d, data2_q, data2_d, imm_q, imm_d;
   logic [3:0]            alu_q, alu_d;
   logic [4:0]            rd_q, rd_d;
   logic                  src_q, src_d, rw_q, rw_d, mr_q, mr_d, mw_q, mw_d;
   logic                  br_q, br_d, ill_q, ill_d;

   assign opcode_s = instr_i[6:0];
   assign funct3_s = instr_i[14:12];
   assign funct7_s = instr_i[31:25];

   decode_stage_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_COUNT  (REG_COUNT)
   ) u_regfile (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .we_i     (wb_en_i),
      .waddr_i  (wb_rd_i),
      .wdata_i  (wb_data_i),
      .raddr1_i (instr_i[19:15]),
      .raddr2_i (instr_i[24:20]),
      .rdata1_o (rdata1_s),
      .rdata2_o (rdata2_s)
   );

   // Instruction decode: raw control per opcode plus a legality flag.
   always_comb begin
      alu_raw_s = ALU_ADD;
      imm_raw_s = {DATA_WIDTH{1'b0}};
      src_raw_s = 1'b0;
      rw_raw_s  = 1'b0;
      mr_raw_s  = 1'b0;
      mw_raw_s  = 1'b0;
      br_raw_s  = 1'b0;
      lui_s     = 1'b0;
      ill_s     = 1'b0;
      case (opcode_s)
         OPC_R: begin
            rw_raw_s = 1'b1;
            case (funct3_s)
               3'b000:  alu_raw_s = funct7_s[5] ? ALU_SUB : ALU_ADD;
               3'b001:  alu_raw_s = ALU_SLL;
               3'b010:  alu_raw_s = ALU_SLT;
               3'b011:  alu_raw_s = ALU_SLTU;
               3'b100:  alu_raw_s = ALU_XOR;
               3'b101:  alu_raw_s = funct7_s[5] ? ALU_SRA : ALU_SRL;
               3'b110:  alu_raw_s = ALU_OR;
               3'b111:  alu_raw_s = ALU_AND;
               default: alu_raw_s = ALU_ADD;
            endcase
            // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
            ill_s = !((funct7_s == 7'b0000000) ||
                      ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101))));
         end
         OPC_IMM: begin
            src_raw_s = 1'b1;
            rw_raw_s  = 1'b1;
            imm_raw_s = imm_gen(instr_i, IMM_I);
            case (funct3_s)
               3'b000: alu_raw_s = ALU_ADD;
               3'b001: begin
                  // Shift amount is the low five immediate bits, zero-extended.
                  alu_raw_s = ALU_SLL;
                  imm_raw_s = {27'd0, instr_i[24:20]};
                  ill_s     = (funct7_s != 7'b0000000);
               end
               3'b010: alu_raw_s = ALU_SLT;
               3'b011: alu_raw_s = ALU_SLTU;
               3'b100: alu_raw_s = ALU_XOR;
               3'b101: begin
                  alu_raw_s = funct7_s[5] ? ALU_SRA : ALU_SRL;
                  imm_raw_s = {27'd0, instr_i[24:20]};
                  ill_s     = !((funct7_s == 7'b0000000) || (funct7_s == 7'b0100000));
               end
               3'b110:  alu_raw_s = ALU_OR;
               3'b111:  alu_raw_s = ALU_AND;
               default: alu_raw_s = ALU_ADD;
            endcase
         end
         OPC_LOAD: begin
            src_raw_s = 1'b1;
            mr_raw_s  = 1'b1;
            rw_raw_s  = 1'b1;
            imm_raw_s = imm_gen(instr_i, IMM_I);
            ill_s     = (funct3_s != 3'b010);
         end
         OPC_STORE: begin
            src_raw_s = 1'b1;
            mw_raw_s  = 1'b1;
            imm_raw_s = imm_gen(instr_i, IMM_S);
            ill_s     = (funct3_s != 3'b010);
         end
         OPC_BRANCH: begin
            alu_raw_s = ALU_SUB;
            br_raw_s  = 1'b1;
            imm_raw_s = imm_gen(instr_i, IMM_B);
            ill_s     = (funct3_s == 3'b010) || (funct3_s == 3'b011);
         end
         OPC_LUI: begin
            src_raw_s = 1'b1;
            rw_raw_s  = 1'b1;
            lui_s     = 1'b1;
            imm_raw_s = imm_gen(instr_i, IMM_U);
         end
         default: ill_s = 1'b1;
      endcase
   end

   assign in_ready_o = !valid_q || out_ready_i;
   assign load_s     = in_valid_i && in_ready_o;

   // Pipeline next state: flush wins over load, load over drain; operands sampled only at load.
   always_comb begin
      valid_d = valid_q;
      data1_d = data1_q;
      data2_d = data2_q;
      imm_d   = imm_q;
      alu_d   = alu_q;
      rd_d    = rd_q;
      src_d   = src_q;
      rw_d    = rw_q;
      mr_d    = mr_q;
      mw_d    = mw_q;
      br_d    = br_q;
      ill_d   = ill_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_s) begin
         valid_d = 1'b1;
         data1_d = lui_s ? {DATA_WIDTH{1'b0}} : rdata1_s;
         data2_d = rdata2_s;
         rd_d    = instr_i[11:7];
         ill_d   = ill_s;
         // An illegal instruction must not cause any side effect downstream.
         alu_d   = ill_s ? ALU_ADD : alu_raw_s;
         imm_d   = ill_s ? {DATA_WIDTH{1'b0}} : imm_raw_s;
         src_d   = src_raw_s && !ill_s;
         rw_d    = rw_raw_s && !ill_s;
         mr_d    = mr_raw_s && !ill_s;
         mw_d    = mw_raw_s && !ill_s;
         br_d    = br_raw_s && !ill_s;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Output pipeline register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data1_q <= {DATA_WIDTH{1'b0}};
         data2_q <= {DATA_WIDTH{1'b0}};
         imm_q   <= {DATA_WIDTH{1'b0}};
         alu_q   <= ALU_ADD;
         rd_q    <= 5'd0;
         src_q   <= 1'b0;
         rw_q    <= 1'b0;
         mr_q    <= 1'b0;
         mw_q    <= 1'b0;
         br_q    <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data1_q <= data1_d;
         data2_q <= data2_d;
         imm_q   <= imm_d;
         alu_q   <= alu_d;
         rd_q    <= rd_d;
         src_q   <= src_d;
         rw_q    <= rw_d;
         mr_q    <= mr_d;
         mw_q    <= mw_d;
         br_q    <= br_d;
         ill_q   <= ill_d;
      end
   end

   assign out_valid_o = valid_q;
   assign reg_data1_o = data1_q;
   assign reg_data2_o = data2_q;
   assign imm_ext_o   = imm_q;
   assign ALUctrl_o   = alu_q;
   assign ALUsrc_o    = src_q;
   assign rd_o        = rd_q;
   assign reg_write_o = rw_q;
   assign mem_read_o  = mr_q;
   assign mem_write_o = mw_q;
   assign branch_o    = br_q;
   assign illegal_o   = ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Directed scenarios followed by randomized traffic for decode_stage, checked
//   against a reference model of the register file and the RV32I decode rules.
module tb_decode_stage;

   logic        clk_i = 1'b0;
   logic        rst_i, in_valid_i, in_ready_o, wb_en_i, flush_i, out_valid_o, out_ready_i;
   logic [31:0] instr_i, wb_data_i, reg_data1_o, reg_data2_o, imm_ext_o;
   logic [4:0]  wb_rd_i, rd_o;
   logic [3:0]  ALUctrl_o;
   logic        ALUsrc_o, reg_write_o, mem_read_o, mem_write_o, branch_o, illegal_o;

   always #5 clk_i = ~clk_i;

   decode_stage dut (
      .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .instr_i(instr_i), .wb_en_i(wb_en_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
      .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .reg_data1_o(reg_data1_o), .reg_data2_o(reg_data2_o), .imm_ext_o(imm_ext_o),
      .ALUctrl_o(ALUctrl_o), .ALUsrc_o(ALUsrc_o), .rd_o(rd_o), .reg_write_o(reg_write_o),
      .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .branch_o(branch_o),
      .illegal_o(illegal_o)
   );

   typedef struct {
      bit        ill, src, rw, mr, mw, br;
      bit [3:0]  alu;
      bit [31:0] imm, d1, d2;
      bit [4:0]  rd;
   } exp_t;

   int        total = 0;
   int        bad   = 0;
   bit [31:0] rf_m [32];
   bit [3:0]  alu_tab [8];
   bit        m_valid = 1'b0;
   bit        m_show  = 1'b0;
   exp_t      m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference decode straight from the RV32I field definitions.
   function automatic exp_t ref_decode(input logic [31:0] ins);
      exp_t      e;
      int        v;
      bit [6:0]  f7  = ins[31:25];
      bit [2:0]  f3  = ins[14:12];
      bit        alt = (f7 == 7'h20);
      bit        shift;
      e = '{default: 0};
      e.d1 = rf_m[ins[19:15]];
      e.d2 = rf_m[ins[24:20]];
      e.rd = ins[11:7];
      case (ins[6:0])
         7'b0110011: begin
            e.rw  = 1'b1;
            e.alu = alu_tab[f3] + ((alt && (f3 == 3'd0 || f3 == 3'd5)) ? 4'd1 : 4'd0);
            e.ill = !(f7 == 7'h00 || (alt && (f3 == 3'd0 || f3 == 3'd5)));
         end
         7'b0010011: begin
            shift = (f3 == 3'd1 || f3 == 3'd5);
            e.rw  = 1'b1;
            e.src = 1'b1;
            e.alu = alu_tab[f3] + ((alt && f3 == 3'd5) ? 4'd1 : 4'd0);
            v     = $signed(ins[31:20]);
            e.imm = shift ? 32'(ins[24:20]) : 32'(v);
            e.ill = shift && !(f7 == 7'h00 || (alt && f3 == 3'd5));
         end
         7'b0000011: begin
            e.rw = 1'b1; e.mr = 1'b1; e.src = 1'b1;
            v     = $signed(ins[31:20]);
            e.imm = 32'(v);
            e.ill = (f3 != 3'd2);
         end
         7'b0100011: begin
            e.mw = 1'b1; e.src = 1'b1;
            v     = $signed({ins[31:25], ins[11:7]});
            e.imm = 32'(v);
            e.ill = (f3 != 3'd2);
         end
         7'b1100011: begin
            e.br = 1'b1; e.alu = 4'd1;
            v     = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
            e.imm = 32'(v);
            e.ill = (f3 == 3'd2 || f3 == 3'd3);
         end
         7'b0110111: begin
            e.rw = 1'b1; e.src = 1'b1;
            e.imm = ins & 32'hFFFF_F000;
            e.d1  = 32'd0;
         end
         default: e.ill = 1'b1;
      endcase
      if (e.ill) begin
         e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0; e.alu = 4'd0;
      end
      return e;
   endfunction

   // One clock: check in_ready, advance the model, then check outputs after the edge.
   task automatic tick();
      bit ld;
      #1;
      if (!rst_i) chk("in_ready", in_ready_o, !m_valid || out_ready_i);
      if (rst_i) begin
         foreach (rf_m[i]) rf_m[i] = 32'd0;
         m_valid = 1'b0;
         m_show  = 1'b1;
         m = '{default: 0};
      end else begin
         if (wb_en_i && wb_rd_i != 5'd0) rf_m[wb_rd_i] = wb_data_i;
         ld = in_valid_i && (!m_valid || out_ready_i);
         if (flush_i) m_valid = 1'b0;
         else if (ld) begin
            m = ref_decode(instr_i);
            m_valid = 1'b1;
            m_show  = 1'b0;
         end else if (out_ready_i) m_valid = 1'b0;
      end
      @(posedge clk_i);
      #1;
      chk("out_valid", out_valid_o, m_valid);
      if (m_valid || m_show) begin
         chk("illegal", illegal_o, m.ill);
         chk("reg_write", reg_write_o, m.rw);
         chk("mem_read", mem_read_o, m.mr);
         chk("mem_write", mem_write_o, m.mw);
         chk("branch", branch_o, m.br);
         chk("ALUctrl", ALUctrl_o, m.alu);
         if (!m.ill) begin
            chk("ALUsrc", ALUsrc_o, m.src);
            chk("imm_ext", imm_ext_o, m.imm);
            chk("reg_data1", reg_data1_o, m.d1);
            chk("reg_data2", reg_data2_o, m.d2);
         end
         if (m.rw || m_show) chk("rd", rd_o, m.rd);
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w  = $urandom;
      logic [6:0]  f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      case ($urandom_range(0, 7))
         0, 1: begin w[6:0] = 7'b0110011; if ($urandom_range(0, 7) != 0) w[31:25] = f7; end
         2:    begin w[6:0] = 7'b0010011; if ($urandom_range(0, 3) != 0) w[31:25] = f7; end
         3:    begin w[6:0] = 7'b0000011; if ($urandom_range(0, 7) != 0) w[14:12] = 3'b010; end
         4:    begin w[6:0] = 7'b0100011; if ($urandom_range(0, 7) != 0) w[14:12] = 3'b010; end
         5:    w[6:0] = 7'b1100011;
         6:    w[6:0] = 7'b0110111;
         default: w[0] = w[0];
      endcase
      return w;
   endfunction

   initial begin
      alu_tab = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
      rst_i = 1'b1; in_valid_i = 1'b0; instr_i = 32'd0; wb_en_i = 1'b0; wb_rd_i = 5'd0;
      wb_data_i = 32'd0; flush_i = 1'b0; out_ready_i = 1'b1;
      tick(); tick();
      chk("rst_valid", out_valid_o, 1'b0);
      chk("rst_data1", reg_data1_o, 32'd0);
      chk("rst_imm", imm_ext_o, 32'd0);
      rst_i = 1'b0;

      // 1: writeback x5, x6 then add x7,x5,x6
      wb_en_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h10; tick();
      wb_rd_i = 5'd6; wb_data_i = 32'h3; tick();
      wb_en_i = 1'b0; in_valid_i = 1'b1; instr_i = 32'h0062_83B3; tick();
      chk("t1_data1", reg_data1_o, 32'h10);
      chk("t1_data2", reg_data2_o, 32'h3);
      chk("t1_alu", ALUctrl_o, 32'h0);
      chk("t1_rd", rd_o, 32'd7);

      // 2: addi x1,x0,-1 ; sw x2,8(x3)
      instr_i = 32'hFFF0_0093; tick();
      chk("t2_imm", imm_ext_o, 32'hFFFF_FFFF);
      chk("t2_src", ALUsrc_o, 1'b1);
      instr_i = 32'h0021_A423; tick();
      chk("t2_sw_imm", imm_ext_o, 32'd8);
      chk("t2_sw_mw", mem_write_o, 1'b1);

      // 3: stall three cycles, then release
      out_ready_i = 1'b0; instr_i = 32'h0062_83B3;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_hold_imm", imm_ext_o, 32'd8);
         chk("t3_in_ready", in_ready_o, 1'b0);
      end
      out_ready_i = 1'b1; tick();
      chk("t3_release_rd", rd_o, 32'd7);

      // 4: write-through of x5, then x0 ignores writes
      wb_en_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'hAA; tick();
      chk("t4_bypass", reg_data1_o, 32'hAA);
      wb_rd_i = 5'd0; wb_data_i = 32'h55; instr_i = 32'h0000_03B3; tick();
      chk("t4_x0", reg_data1_o, 32'd0);
      wb_en_i = 1'b0;

      // 5: flush over a held instr, then illegal word
      out_ready_i = 1'b0; instr_i = 32'h0021_A423; tick();
      flush_i = 1'b1; tick();
      chk("t5_flush", out_valid_o, 1'b0);
      flush_i = 1'b0; out_ready_i = 1'b1; instr_i = 32'hFFFF_FFFF; tick();
      chk("t5_illegal", illegal_o, 1'b1);
      chk("t5_rw", reg_write_o, 1'b0);

      // 6: beq x1,x2,-4 ; lui x4,0x12345
      instr_i = 32'hFE20_8EE3; tick();
      chk("t6_beq_alu", ALUctrl_o, 32'd1);
      chk("t6_beq_imm", imm_ext_o, 32'hFFFF_FFFC);
      instr_i = 32'h1234_5237; tick();
      chk("t6_lui_imm", imm_ext_o, 32'h1234_5000);

      // reset while stalled drops the instr and clears the regfile
      wb_en_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h77; instr_i = 32'h0062_83B3; tick();
      wb_en_i = 1'b0; out_ready_i = 1'b0; tick();
      rst_i = 1'b1; tick();
      chk("rst_stall_valid", out_valid_o, 1'b0);
      rst_i = 1'b0; out_ready_i = 1'b1; tick();
      chk("rst_cleared", reg_data1_o, 32'd0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         instr_i     = rand_instr();
         in_valid_i  = ($urandom_range(0, 3) != 0);
         out_ready_i = ($urandom_range(0, 3) != 0);
         flush_i     = ($urandom_range(0, 15) == 0);
         wb_en_i     = ($urandom_range(0, 1) == 1);
         wb_rd_i     = ($urandom_range(0, 1) == 1) ? instr_i[19:15] : 5'($urandom_range(0, 31));
         wb_data_i   = $urandom;
         rst_i       = ($urandom_range(0, 199) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
